// File: rtl/uEyeriss_pkg.sv
// Shared types and helpers for the uEyeriss PE-cluster datapath.
// Holds the partial-sum accumulator state encoding and counter sizing.
package uEyeriss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } psum_accum_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_accum.sv
// Accumulates per-column cluster psums over NUM_PASSES compute_done events,
// then drains the X_dim sums one per beat over a valid/ready stream.
module psum_accum
  import uEyeriss_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int X_dim      = 3,
  parameter int NUM_PASSES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] psum_in [0:X_dim-1],
  input  logic                  psum_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int PASS_W = cnt_width(NUM_PASSES);
  localparam int BEAT_W = cnt_width(X_dim);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(X_dim - 1);

  psum_accum_state_t     state;
  logic [DATA_WIDTH-1:0] acc [0:X_dim-1];
  logic [PASS_W-1:0]     pass_cnt;
  logic [BEAT_W-1:0]     beat_idx;
  logic                  valid_q;
  logic                  pass_evt;

  // A held-high compute_done counts once: only the rising edge is a pass.
  assign pass_evt = psum_valid & ~valid_q;

  // Outputs decode registered state only, so out_ready never reaches them.
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (beat_idx == LAST_BEAT);
  assign out_data  = acc[beat_idx];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: every register here, including the accumulator array, is written
  // with non-blocking assignments and cleared by the async reset so a
  // mid-tile reset discards all partial sums.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pass_cnt <= '0;
      beat_idx <= '0;
      valid_q  <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < X_dim; i++) acc[i] <= '0;
    end else begin
      valid_q <= psum_valid;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < X_dim; i++) acc[i] <= '0;
            pass_cnt <= '0;
            overrun  <= 1'b0;
            state    <= ACCUM;
          end
          // Placed after the start clear so a coincident pass edge still flags.
          if (pass_evt) overrun <= 1'b1;
        end
        ACCUM: begin
          if (pass_evt) begin
            for (int i = 0; i < X_dim; i++) acc[i] <= acc[i] + psum_in[i];
            if (pass_cnt == LAST_PASS) begin
              pass_cnt <= '0;
              beat_idx <= '0;
              state    <= DRAIN;
            end else begin
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pass_evt) overrun <= 1'b1;
          if (out_ready) begin
            if (beat_idx == LAST_BEAT) begin
              beat_idx <= '0;
              state    <= DONE;
            end else begin
              beat_idx <= beat_idx + BEAT_W'(1);
            end
          end
        end
        DONE: begin
          if (pass_evt) overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
